// File: rtl/sdram_sync_fifo_pf_if.sv
// -----------------------------------------------------------------------------
// sdram_sync_fifo_pf_if
// Bus bundle for sdram_sync_fifo_pf. Everything except clock and reset.
//   iREMOVE            synchronous flush request
//   iAF_LEVEL          almost-full threshold  (D_N+1 bits)
//   iAE_LEVEL          almost-empty threshold (D_N+1 bits)
//   oCOUNT             occupancy 0..DEPTH     (D_N+1 bits)
//   iWR_EN/iWR_DATA    push request and data
//   oWR_FULL           occupancy == DEPTH
//   oWR_ALMOST_FULL    occupancy >= iAF_LEVEL
//   iRD_EN             pop request
//   oRD_DATA           head-of-queue word
//   oRD_EMPTY          no word available on oRD_DATA
//   oRD_ALMOST_EMPTY   occupancy <= iAE_LEVEL
//   oOVERFLOW          sticky, a push was rejected
//   oUNDERFLOW         sticky, a pop was rejected
// master: the producer/consumer side; slave: the FIFO itself.
// -----------------------------------------------------------------------------
interface sdram_sync_fifo_pf_if #(
    parameter int N   = 16,
    parameter int D_N = 4
);
    logic           iREMOVE;
    logic [D_N:0]   iAF_LEVEL;
    logic [D_N:0]   iAE_LEVEL;
    logic [D_N:0]   oCOUNT;
    logic           iWR_EN;
    logic [N-1:0]   iWR_DATA;
    logic           oWR_FULL;
    logic           oWR_ALMOST_FULL;
    logic           iRD_EN;
    logic [N-1:0]   oRD_DATA;
    logic           oRD_EMPTY;
    logic           oRD_ALMOST_EMPTY;
    logic           oOVERFLOW;
    logic           oUNDERFLOW;

    modport master (
        output iREMOVE, iAF_LEVEL, iAE_LEVEL, iWR_EN, iWR_DATA, iRD_EN,
        input  oCOUNT, oWR_FULL, oWR_ALMOST_FULL, oRD_DATA, oRD_EMPTY,
               oRD_ALMOST_EMPTY, oOVERFLOW, oUNDERFLOW
    );

    modport slave (
        input  iREMOVE, iAF_LEVEL, iAE_LEVEL, iWR_EN, iWR_DATA, iRD_EN,
        output oCOUNT, oWR_FULL, oWR_ALMOST_FULL, oRD_DATA, oRD_EMPTY,
               oRD_ALMOST_EMPTY, oOVERFLOW, oUNDERFLOW
    );
endinterface

// File: rtl/sdram_sync_fifo_pf.sv
// -----------------------------------------------------------------------------
// sdram_sync_fifo_pf
// Single-clock FIFO used for the SDRAM controller's command, write-data and
// read-return queues. Adds programmable almost-full/almost-empty thresholds,
// a registered occupancy count, rejection of illegal pushes/pops with sticky
// error flags, and an optional first-word-fall-through output register.
// Ports:
//   iCLOCK   clock, all state changes on the rising edge
//   inRESET  asynchronous active-low reset
//   bus      sdram_sync_fifo_pf_if.slave (flush, thresholds, push, pop, flags)
// Parameters:
//   N        data width
//   DEPTH    capacity, must equal 2**D_N
//   D_N      log2(DEPTH), at least 1
//   OUT_REG  0: oRD_DATA read straight from memory
//            1: oRD_DATA from a first-word-fall-through register
// -----------------------------------------------------------------------------
module sdram_sync_fifo_pf #(
    parameter int N       = 16,
    parameter int DEPTH   = 16,
    parameter int D_N     = 4,
    parameter int OUT_REG = 0
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    sdram_sync_fifo_pf_if.slave       bus
);

    localparam logic [D_N:0] LP_DEPTH = (D_N+1)'(DEPTH);
    localparam logic [D_N:0] LP_ONE   = (D_N+1)'(1);

    logic [N-1:0]  r_mem [DEPTH];
    logic [D_N:0]  r_wptr;
    logic [D_N:0]  r_rptr;
    logic [D_N:0]  r_count;
    logic          r_ov;
    logic [N-1:0]  r_out_data;
    logic          r_ovf;
    logic          r_unf;

    logic          w_empty;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic [D_N:0]  w_mem_cnt;
    logic          w_load;
    logic          w_rd_adv;
    logic          w_unused_wrap;

    always_comb begin
        w_empty   = (OUT_REG != 0) ? !r_ov : (r_count == '0);
        w_pop_ok  = bus.iRD_EN && !w_empty;
        // A full FIFO can still take a push when the same edge frees a slot.
        w_push_ok = bus.iWR_EN && ((r_count != LP_DEPTH) || w_pop_ok);
        // Words still in memory: the output register holds one of the counted words.
        w_mem_cnt = r_count - {{D_N{1'b0}}, r_ov};
        w_load    = (OUT_REG != 0) && (w_mem_cnt != '0) && (!r_ov || w_pop_ok);
        w_rd_adv  = (OUT_REG != 0) ? w_load : w_pop_ok;
    end

    // Occupancy lives in r_count, so the pointer wrap bits feed no flag logic.
    assign w_unused_wrap = r_wptr[D_N] ^ r_rptr[D_N];

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ov       <= 1'b0;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (bus.iREMOVE) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ov    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + LP_ONE;
            if (w_rd_adv)
                r_rptr <= r_rptr + LP_ONE;

            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + LP_ONE;
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - LP_ONE;

            // Refill the output register on the same edge it is popped: no bubble.
            if (w_load) begin
                r_ov       <= 1'b1;
                r_out_data <= r_mem[r_rptr[D_N-1:0]];
            end else if (w_pop_ok) begin
                r_ov <= 1'b0;
            end

            if (bus.iWR_EN && !w_push_ok)
                r_ovf <= 1'b1;
            if (bus.iRD_EN && w_empty)
                r_unf <= 1'b1;
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge iCLOCK) begin
        if (!bus.iREMOVE && w_push_ok)
            r_mem[r_wptr[D_N-1:0]] <= bus.iWR_DATA;
    end

    assign bus.oCOUNT           = r_count;
    assign bus.oWR_FULL         = (r_count == LP_DEPTH);
    assign bus.oWR_ALMOST_FULL  = (r_count >= bus.iAF_LEVEL);
    assign bus.oRD_ALMOST_EMPTY = (r_count <= bus.iAE_LEVEL);
    assign bus.oRD_EMPTY        = w_empty;
    assign bus.oRD_DATA         = (OUT_REG != 0) ? r_out_data : r_mem[r_rptr[D_N-1:0]];
    assign bus.oOVERFLOW        = r_ovf;
    assign bus.oUNDERFLOW       = r_unf;

endmodule

// File: tb/tb_sdram_sync_fifo_pf.sv
// -----------------------------------------------------------------------------
// tb_sdram_sync_fifo_pf
// Drives one OUT_REG=0 and one OUT_REG=1 instance with identical stimulus and
// compares every output each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sdram_sync_fifo_pf;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic        rm;
    logic [4:0]  af_lvl;
    logic [4:0]  ae_lvl;

    int n_vec;
    int n_bad;

    // Reference model state, index = OUT_REG value
    logic [15:0] mq [2][$];
    logic        mov  [2];
    logic        movf [2];
    logic        munf [2];

    sdram_sync_fifo_pf_if #(.N(16), .D_N(4)) bus0 ();
    sdram_sync_fifo_pf_if #(.N(16), .D_N(4)) bus1 ();

    assign bus0.iREMOVE   = rm;
    assign bus0.iAF_LEVEL = af_lvl;
    assign bus0.iAE_LEVEL = ae_lvl;
    assign bus0.iWR_EN    = wr_en;
    assign bus0.iWR_DATA  = wr_data;
    assign bus0.iRD_EN    = rd_en;
    assign bus1.iREMOVE   = rm;
    assign bus1.iAF_LEVEL = af_lvl;
    assign bus1.iAE_LEVEL = ae_lvl;
    assign bus1.iWR_EN    = wr_en;
    assign bus1.iWR_DATA  = wr_data;
    assign bus1.iRD_EN    = rd_en;

    sdram_sync_fifo_pf #(.N(16), .DEPTH(16), .D_N(4), .OUT_REG(0)) u_dut0 (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus0)
    );

    sdram_sync_fifo_pf #(.N(16), .DEPTH(16), .D_N(4), .OUT_REG(1)) u_dut1 (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mov[m]  = 1'b0;
            movf[m] = 1'b0;
            munf[m] = 1'b0;
        end
    endtask

    // One clock edge of the queue model, evaluated from pre-edge state.
    task automatic model_edge();
        int   cnt;
        logic emp, pop, push, load;
        for (int m = 0; m < 2; m++) begin
            cnt  = mq[m].size();
            emp  = (m == 1) ? !mov[m] : (cnt == 0);
            pop  = rd_en && !emp;
            push = wr_en && ((cnt < 16) || pop);
            if (rm) begin
                mq[m].delete();
                mov[m]  = 1'b0;
                movf[m] = 1'b0;
                munf[m] = 1'b0;
            end else begin
                if (wr_en && !push) movf[m] = 1'b1;
                if (rd_en && emp)   munf[m] = 1'b1;
                load = (m == 1) && ((cnt - int'(mov[m])) > 0) && (!mov[m] || pop);
                if (pop)  void'(mq[m].pop_front());
                if (push) mq[m].push_back(wr_data);
                if (m == 1) mov[m] = load ? 1'b1 : (pop ? 1'b0 : mov[m]);
            end
        end
    endtask

    task automatic cmp_one(input int m, input logic [4:0] cnt, input logic full,
                           input logic af, input logic ae, input logic emp,
                           input logic ovf, input logic unf, input logic [15:0] data);
        int   ec;
        logic ee;
        ec = mq[m].size();
        ee = (m == 1) ? !mov[m] : (ec == 0);
        chk($sformatf("m%0d count", m), 32'(cnt), 32'(ec));
        chk($sformatf("m%0d full", m), 32'(full), 32'(ec == 16));
        chk($sformatf("m%0d almost_full", m), 32'(af), 32'(ec >= int'(af_lvl)));
        chk($sformatf("m%0d almost_empty", m), 32'(ae), 32'(ec <= int'(ae_lvl)));
        chk($sformatf("m%0d empty", m), 32'(emp), 32'(ee));
        chk($sformatf("m%0d overflow", m), 32'(ovf), 32'(movf[m]));
        chk($sformatf("m%0d underflow", m), 32'(unf), 32'(munf[m]));
        if (!ee)
            chk($sformatf("m%0d data", m), 32'(data), 32'(mq[m][0]));
    endtask

    task automatic check_all();
        cmp_one(0, bus0.oCOUNT, bus0.oWR_FULL, bus0.oWR_ALMOST_FULL, bus0.oRD_ALMOST_EMPTY,
                bus0.oRD_EMPTY, bus0.oOVERFLOW, bus0.oUNDERFLOW, bus0.oRD_DATA);
        cmp_one(1, bus1.oCOUNT, bus1.oWR_FULL, bus1.oWR_ALMOST_FULL, bus1.oRD_ALMOST_EMPTY,
                bus1.oRD_EMPTY, bus1.oOVERFLOW, bus1.oUNDERFLOW, bus1.oRD_DATA);
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic x);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rm      = x;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Reset values written out as constants, independent of the model.
    task automatic chk_reset_vals(input string tag);
        chk({tag, " m0 count"}, 32'(bus0.oCOUNT), 32'd0);
        chk({tag, " m1 count"}, 32'(bus1.oCOUNT), 32'd0);
        chk({tag, " m0 empty"}, 32'(bus0.oRD_EMPTY), 32'd1);
        chk({tag, " m1 empty"}, 32'(bus1.oRD_EMPTY), 32'd1);
        chk({tag, " m0 full"}, 32'(bus0.oWR_FULL), 32'd0);
        chk({tag, " m1 full"}, 32'(bus1.oWR_FULL), 32'd0);
        chk({tag, " m0 overflow"}, 32'(bus0.oOVERFLOW), 32'd0);
        chk({tag, " m1 underflow"}, 32'(bus1.oUNDERFLOW), 32'd0);
        chk({tag, " m0 almost_full"}, 32'(bus0.oWR_ALMOST_FULL), 32'(af_lvl == 5'd0));
        chk({tag, " m1 almost_empty"}, 32'(bus1.oRD_ALMOST_EMPTY), 32'd1);
        chk({tag, " m1 data"}, 32'(bus1.oRD_DATA), 32'd0);
    endtask

    initial begin
        int pw, pr;
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        rm      = 1'b0;
        af_lvl  = 5'd12;
        ae_lvl  = 5'd3;
        model_clear();

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Fill and drain
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

        // Threshold sweep, occupancy 2 <-> 14
        step(1'b1, 16'h0A00, 1'b0, 1'b0);
        step(1'b1, 16'h0A01, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
            for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Underflow, then overflow on a full FIFO
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("underflow sticky", 32'(bus0.oUNDERFLOW), 32'd1);
        chk("underflow count", 32'(bus0.oCOUNT), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("overflow m0", 32'(bus0.oOVERFLOW), 32'd1);
        chk("overflow m1", 32'(bus1.oOVERFLOW), 32'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 20; i++) step(1'b1, 16'hBE00 + 16'(i), 1'b1, 1'b0);
        chk("full pp count", 32'(bus1.oCOUNT), 32'd16);

        // Flush at count 9 with overflow set, push and pop also requested
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("pre-flush count", 32'(bus0.oCOUNT), 32'd9);
        step(1'b1, 16'h5555, 1'b1, 1'b1);
        chk("flush count", 32'(bus1.oCOUNT), 32'd0);
        chk("flush overflow", 32'(bus1.oOVERFLOW), 32'd0);

        // First-word-fall-through latency
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("lat edge1 m1 empty", 32'(bus1.oRD_EMPTY), 32'd1);
        chk("lat edge1 m1 count", 32'(bus1.oCOUNT), 32'd1);
        chk("lat edge1 m0 data", 32'(bus0.oRD_DATA), 32'h1234);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("lat edge2 m1 empty", 32'(bus1.oRD_EMPTY), 32'd0);
        chk("lat edge2 m1 data", 32'(bus1.oRD_DATA), 32'h1234);

        // Randomized traffic with shifting bias and thresholds
        for (int i = 0; i < 2000; i++) begin
            if ((i % 100) == 0) begin
                af_lvl = 5'($urandom_range(0, 17));
                ae_lvl = 5'($urandom_range(0, 17));
                pw = $urandom_range(20, 90);
                pr = $urandom_range(20, 90);
            end
            step(($urandom_range(0, 99) < pw), 16'($urandom),
                 ($urandom_range(0, 99) < pr), ($urandom_range(0, 299) == 0));
        end

        // Asynchronous reset mid-cycle with data in flight
        af_lvl = 5'd12;
        ae_lvl = 5'd3;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        wr_en = 1'b0;
        rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
